// File: rtl/sink_pkg.sv
// Shared TIS value constants and width helpers for the sink family.
package sink_pkg;

    localparam int unsigned VALUE_W = 11;
    localparam int          VAL_MAX = 999;
    localparam int          VAL_MIN = -999;

    function automatic int unsigned chan_w(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/multi_sink_if.sv
// Producer-side pulse handshake plus downstream valid/ready stream of multi_sink.
interface multi_sink_if
    import sink_pkg::*;
#(
    parameter int unsigned WIDTH    = VALUE_W,
    parameter int unsigned CHANNELS = 4,
    parameter int unsigned DEPTH    = 8
) ();

    localparam int unsigned CW = chan_w(CHANNELS);
    localparam int unsigned LW = $clog2(DEPTH + 1);

    logic [CHANNELS-1:0]       rready;
    logic [CHANNELS*WIDTH-1:0] in;
    logic [CHANNELS-1:0]       read;
    logic                      out_valid;
    logic                      out_ready;
    logic [WIDTH-1:0]          out_data;
    logic [CW-1:0]             out_chan;
    logic [LW-1:0]             level;

    modport master (
        output rready, in, out_ready,
        input  read, out_valid, out_data, out_chan, level
    );

    modport slave (
        input  rready, in, out_ready,
        output read, out_valid, out_data, out_chan, level
    );

endinterface

// File: rtl/sink_fifo.sv
// Synchronous FIFO; head is read combinationally from storage, which is cleared on reset.
module sink_fifo #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 8
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         push,
    input  logic                         pop,
    input  logic [WIDTH-1:0]             wdata,
    output logic [WIDTH-1:0]             rdata,
    output logic                         full,
    output logic                         empty,
    output logic [$clog2(DEPTH+1)-1:0]   level
);

    localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned LW = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];
    logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [LW-1:0]    level_q, level_d;
    logic             do_push, do_pop;

    assign full  = (level_q == LW'(DEPTH));
    assign empty = (level_q == '0);
    assign level = level_q;
    assign rdata = mem_q[rd_ptr_q];

    always_comb begin
        do_push  = push && !full;
        do_pop   = pop && !empty;
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        level_d  = level_q;
        if (do_push) begin
            mem_d[wr_ptr_q] = wdata;
            wr_ptr_d        = wr_ptr_q + 1'b1;
        end
        if (do_pop) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
        if (do_push && !do_pop) begin
            level_d = level_q + 1'b1;
        end else if (!do_push && do_pop) begin
            level_d = level_q - 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
        end
    end

endmodule

// File: rtl/multi_sink.sv
// Round-robin collector: pulse-acknowledged producers into one channel-tagged FIFO.
module multi_sink
    import sink_pkg::*;
#(
    parameter int unsigned WIDTH    = VALUE_W,
    parameter int unsigned CHANNELS = 4,
    parameter int unsigned DEPTH    = 8
) (
    input  logic       clk,
    input  logic       rst,
    multi_sink_if.slave bus
);

    localparam int unsigned CW = chan_w(CHANNELS);
    localparam int unsigned LW = $clog2(DEPTH + 1);
    localparam int unsigned EW = CW + WIDTH;

    logic [CHANNELS-1:0] read_q, read_d;
    logic [CW-1:0]       ptr_q, ptr_d;
    logic [CHANNELS-1:0] eligible;
    logic [WIDTH-1:0]    in_vals [CHANNELS];
    logic [CW-1:0]       grant_idx;
    logic [CW-1:0]       cand;
    logic                grant_found;
    int unsigned         scan_idx;
    int unsigned         next_ptr;
    logic                push, pop, full, empty;
    logic [EW-1:0]       wdata, rdata;
    logic [LW-1:0]       level;

    for (genvar g = 0; g < CHANNELS; g++) begin : g_unpack
        assign in_vals[g] = bus.in[g*WIDTH +: WIDTH];
    end

    // A channel whose acknowledge is still high has not yet retired its old value.
    always_comb begin
        eligible    = bus.rready & ~read_q;
        grant_found = 1'b0;
        grant_idx   = '0;
        cand        = '0;
        scan_idx    = 0;
        for (int unsigned k = 0; k < CHANNELS; k++) begin
            scan_idx = 32'(ptr_q) + k;
            if (scan_idx >= CHANNELS) begin
                scan_idx = scan_idx - CHANNELS;
            end
            cand = CW'(scan_idx);
            if (!grant_found && eligible[cand]) begin
                grant_found = 1'b1;
                grant_idx   = cand;
            end
        end
    end

    always_comb begin
        push     = grant_found && !full;
        read_d   = '0;
        ptr_d    = ptr_q;
        next_ptr = 32'(grant_idx) + 1;
        if (next_ptr >= CHANNELS) begin
            next_ptr = 0;
        end
        if (push) begin
            read_d[grant_idx] = 1'b1;
            ptr_d             = CW'(next_ptr);
        end
        wdata = {grant_idx, in_vals[grant_idx]};
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            read_q <= '0;
            ptr_q  <= '0;
        end else begin
            read_q <= read_d;
            ptr_q  <= ptr_d;
        end
    end

    assign pop = !empty && bus.out_ready;

    sink_fifo #(
        .WIDTH (EW),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push),
        .pop   (pop),
        .wdata (wdata),
        .rdata (rdata),
        .full  (full),
        .empty (empty),
        .level (level)
    );

    assign bus.read      = read_q;
    assign bus.out_valid = !empty;
    assign bus.out_data  = rdata[WIDTH-1:0];
    assign bus.out_chan  = rdata[EW-1 -: CW];
    assign bus.level     = level;

endmodule

// File: tb/tb_multi_sink.sv
// Scoreboard bench for multi_sink: per-channel producer queues feed the DUT, a monitor checks the stream.
module tb_multi_sink;
    import sink_pkg::*;

    localparam int unsigned W  = VALUE_W;
    localparam int unsigned CH = 4;
    localparam int unsigned D  = 8;
    localparam int unsigned CW = chan_w(CH);
    localparam int unsigned LW = $clog2(D + 1);

    typedef struct packed {
        logic [CW-1:0] chan;
        logic [W-1:0]  data;
    } entry_t;

    logic clk = 1'b0;
    logic rst = 1'b1;

    int checks   = 0;
    int failures = 0;

    entry_t      sb [$];
    logic [W-1:0] pq [CH][$];

    multi_sink_if #(.WIDTH(W), .CHANNELS(CH), .DEPTH(D)) bus ();

    multi_sink #(.WIDTH(W), .CHANNELS(CH), .DEPTH(D)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic expect_entry(input int unsigned c, input logic [W-1:0] d);
        entry_t e;
        e.chan = CW'(c);
        e.data = d;
        sb.push_back(e);
    endtask

    // Producer model: hold value until its acknowledge pulse, then advance.
    initial begin
        bus.rready = '0;
        bus.in     = '0;
        forever begin
            @(negedge clk);
            for (int i = 0; i < CH; i++) begin
                if (bus.read[i] && pq[i].size() > 0) begin
                    void'(pq[i].pop_front());
                end
                if (pq[i].size() > 0) begin
                    bus.rready[i]     = 1'b1;
                    bus.in[i*W +: W]  = pq[i][0];
                end else begin
                    bus.rready[i] = 1'b0;
                end
            end
        end
    end

    // Monitor: every accepted output beat is compared against the scoreboard head.
    initial begin
        entry_t e;
        forever begin
            @(negedge clk);
            if (!rst && bus.out_valid && bus.out_ready) begin
                if (sb.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL sb_unexpected: got chan %0d data 0x%0h expected no entry",
                             bus.out_chan, bus.out_data);
                end else begin
                    e = sb.pop_front();
                    check("sb_chan", 32'(bus.out_chan), 32'(e.chan));
                    check("sb_data", 32'(bus.out_data), 32'(e.data));
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got no finish expected finish");
        $fatal(1, "timeout");
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_queues();
        sb.delete();
        for (int i = 0; i < CH; i++) pq[i].delete();
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        #1;
        check("rst_read",      32'(bus.read),      32'h0);
        check("rst_out_valid", 32'(bus.out_valid), 32'h0);
        check("rst_level",     32'(bus.level),     32'h0);
        check("rst_out_data",  32'(bus.out_data),  32'h0);
        check("rst_out_chan",  32'(bus.out_chan),  32'h0);
        clear_queues();
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic drain(input string name);
        logic done;
        done = 1'b0;
        cyc();
        bus.out_ready = 1'b1;
        for (int n = 0; n < 100 && !done; n++) begin
            @(negedge clk);
            if (sb.size() == 0 && bus.level == '0 && bus.rready == '0) done = 1'b1;
        end
        check(name, 32'(done), 32'h1);
        cyc();
        bus.out_ready = 1'b0;
    endtask

    task automatic wait_level(input string name, input int unsigned target);
        logic hit;
        hit = 1'b0;
        for (int n = 0; n < 60 && !hit; n++) begin
            @(negedge clk);
            if (bus.level == LW'(target)) hit = 1'b1;
        end
        check(name, 32'(hit), 32'h1);
    endtask

    initial begin
        logic [CH-1:0] prev;
        bus.out_ready = 1'b0;
        do_reset();

        // Single value on channel 2
        cyc();
        pq[2].push_back(11'd37);
        expect_entry(2, 11'd37);
        @(negedge clk);
        check("t1_read_before", 32'(bus.read), 32'h0);
        @(negedge clk);
        check("t1_read_pulse", 32'(bus.read),      32'h4);
        check("t1_valid",      32'(bus.out_valid), 32'h1);
        check("t1_level",      32'(bus.level),     32'h1);
        check("t1_data",       32'(bus.out_data),  32'd37);
        check("t1_chan",       32'(bus.out_chan),  32'd2);
        @(negedge clk);
        check("t1_read_clear", 32'(bus.read), 32'h0);
        check("t1_level_hold", 32'(bus.level), 32'h1);
        drain("t1_drain");

        // Fairness with all channels streaming
        do_reset();
        cyc();
        bus.out_ready = 1'b1;
        for (int k = 0; k < 2; k++) begin
            for (int i = 0; i < CH; i++) begin
                pq[i].push_back(W'(4 * k + i + 1));
                expect_entry(i, W'(4 * k + i + 1));
            end
        end
        prev = '0;
        for (int n = 0; n < 12; n++) begin
            @(negedge clk);
            check("t2_no_back_to_back", 32'(bus.read & prev), 32'h0);
            prev = bus.read;
        end
        drain("t2_drain");

        // Backpressure until full, then a single pop
        do_reset();
        for (int k = 0; k < 3; k++) begin
            for (int i = 0; i < CH; i++) begin
                pq[i].push_back(W'(100 * i + k + 1));
                expect_entry(i, W'(100 * i + k + 1));
            end
        end
        wait_level("t3_reach_full", 8);
        for (int n = 0; n < 3; n++) begin
            @(negedge clk);
            check("t3_no_read_full", 32'(bus.read),  32'h0);
            check("t3_level_full",   32'(bus.level), 32'd8);
        end
        cyc();
        bus.out_ready = 1'b1;
        @(negedge clk);
        check("t3_full_no_read", 32'(bus.read), 32'h0);
        cyc();
        bus.out_ready = 1'b0;
        @(negedge clk);
        check("t3_level_after_pop", 32'(bus.level), 32'd7);
        check("t3_no_write_through", 32'(bus.read), 32'h0);
        @(negedge clk);
        check("t3_next_accept", 32'(bus.read),  32'h1);
        check("t3_level_refill", 32'(bus.level), 32'd8);
        drain("t3_drain");

        // Boundary values on channel 1
        cyc();
        pq[1].push_back(W'(VAL_MIN));
        pq[1].push_back(W'(VAL_MAX));
        expect_entry(1, 11'h419);
        expect_entry(1, 11'h3E7);
        drain("t4_drain");

        // Simultaneous push and pop at level 3
        do_reset();
        for (int i = 0; i < 3; i++) begin
            pq[i].push_back(W'(51 + i));
            expect_entry(i, W'(51 + i));
        end
        wait_level("t5_reach_3", 3);
        cyc();
        bus.out_ready = 1'b1;
        pq[3].push_back(11'd54);
        pq[0].push_back(11'd55);
        expect_entry(3, 11'd54);
        expect_entry(0, 11'd55);
        @(negedge clk);
        check("t5_level_a", 32'(bus.level), 32'd3);
        @(negedge clk);
        check("t5_level_b", 32'(bus.level), 32'd3);
        @(negedge clk);
        check("t5_level_c", 32'(bus.level), 32'd3);
        drain("t5_drain");

        // Reset mid-stream with level 5 and a pending acknowledge
        do_reset();
        pq[0].push_back(11'd61);
        pq[0].push_back(11'd62);
        pq[0].push_back(11'd63);
        pq[1].push_back(11'd64);
        pq[2].push_back(11'd65);
        pq[3].push_back(11'd66);
        wait_level("t6_reach_5", 5);
        check("t6_read_pending", 32'(bus.read), 32'h1);
        #1;
        rst = 1'b1;
        #1;
        check("t6_rst_read",  32'(bus.read),      32'h0);
        check("t6_rst_valid", 32'(bus.out_valid), 32'h0);
        check("t6_rst_level", 32'(bus.level),     32'h0);
        clear_queues();
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        cyc();
        pq[3].push_back(11'd77);
        pq[2].push_back(11'd76);
        expect_entry(2, 11'd76);
        expect_entry(3, 11'd77);
        @(negedge clk);
        @(negedge clk);
        check("t6_first_after_rst", 32'(bus.read), 32'h4);
        drain("t6_drain");

        check("sb_empty_end", 32'(sb.size()), 32'h0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
